// File: rtl/vip_morph_pkg.sv
// Shared types and constants for the binary 3x3 morphology engine:
// mode encodings, frame FSM states, stage-1 record and the per-window result function.
package vip_morph_pkg;

    localparam int CNT_W_DEF = 12;

    localparam logic [1:0] MODE_BYPASS = 2'b00;
    localparam logic [1:0] MODE_ERODE  = 2'b01;
    localparam logic [1:0] MODE_DILATE = 2'b10;
    localparam logic [1:0] MODE_EDGE   = 2'b11;

    typedef enum logic {
        FRM_IDLE   = 1'b0,
        FRM_ACTIVE = 1'b1
    } frm_state_e;

    // Row reductions are kept per row so stage 2 only needs a 3-input AND/OR.
    typedef struct packed {
        logic [2:0] row_and;
        logic [2:0] row_or;
        logic       centre;
        logic       border;
    } stage1_t;

    function automatic logic morph_pixel(input logic [1:0] mode, input stage1_t s1);
        logic ero;
        logic dil;
        logic res;
        ero = &s1.row_and;
        dil = |s1.row_or;
        case (mode)
            MODE_BYPASS: res = s1.centre;
            MODE_ERODE:  res = ero;
            MODE_DILATE: res = dil;
            MODE_EDGE:   res = dil & ~ero;
            default:     res = s1.centre;
        endcase
        morph_pixel = res;
    endfunction

endpackage

// File: rtl/vip_frame_pos_cnt.sv
// Row/column position tracker for the morphology engine; flags pixels on the image border.
// Only instantiated when VIP_MORPH_BORDER_MASK_EN is defined.
module vip_frame_pos_cnt
    import vip_morph_pkg::*;
#(
    parameter int IMG_H_DISP = 640,
    parameter int IMG_V_DISP = 480,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic href_i,
    input  logic href_prev_i,
    input  logic clken_i,
    input  logic vsync_rise_i,
    output logic border_o
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(IMG_H_DISP - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(IMG_V_DISP - 1);

    logic [CNT_W-1:0] col_q;
    logic [CNT_W-1:0] col_d;
    logic [CNT_W-1:0] row_q;
    logic [CNT_W-1:0] row_d;
    logic [CNT_W-1:0] col_pos_s;
    logic [CNT_W-1:0] row_pos_s;

    // A vsync edge clears the position before the coincident pixel is classified.
    always_comb begin
        col_pos_s = vsync_rise_i ? CNT_ZERO : col_q;
        row_pos_s = vsync_rise_i ? CNT_ZERO : row_q;
        border_o  = (col_pos_s == CNT_ZERO) || (col_pos_s >= H_LAST) ||
                    (row_pos_s == CNT_ZERO) || (row_pos_s >= V_LAST);

        if (!href_i) begin
            col_d = CNT_ZERO;
        end else if (clken_i && (col_pos_s != CNT_MAX)) begin
            col_d = col_pos_s + CNT_ONE;
        end else begin
            col_d = col_pos_s;
        end

        if (vsync_rise_i) begin
            row_d = CNT_ZERO;
        end else if (href_prev_i && !href_i && (row_q != CNT_MAX)) begin
            row_d = row_q + CNT_ONE;
        end else begin
            row_d = row_q;
        end
    end

    // Position counter registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            col_q <= CNT_ZERO;
            row_q <= CNT_ZERO;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/vip_bin_morph_3x3.sv
// Binary 3x3 morphology engine (bypass / erode / dilate / edge), 2-clock latency, mode latched per frame.
// Border masking is compiled in with VIP_MORPH_BORDER_MASK_EN.
module vip_bin_morph_3x3
    import vip_morph_pkg::*;
#(
    parameter int   IMG_H_DISP = 640,
    parameter int   IMG_V_DISP = 480,
    parameter int   CNT_W      = CNT_W_DEF,
    parameter logic BORDER_VAL = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] mode,
    input  logic       matrix_frame_vsync,
    input  logic       matrix_frame_href,
    input  logic       matrix_frame_clken,
    input  logic       matrix_p11,
    input  logic       matrix_p12,
    input  logic       matrix_p13,
    input  logic       matrix_p21,
    input  logic       matrix_p22,
    input  logic       matrix_p23,
    input  logic       matrix_p31,
    input  logic       matrix_p32,
    input  logic       matrix_p33,
    output logic       post_frame_vsync,
    output logic       post_frame_href,
    output logic       post_frame_clken,
    output logic       post_img_bit
);

    if ((CNT_W < 2) || (IMG_H_DISP < 3) || (IMG_V_DISP < 3) ||
        (IMG_H_DISP >= (1 << CNT_W)) || (IMG_V_DISP >= (1 << CNT_W))) begin : g_cfg_err
        $error("vip_bin_morph_3x3: CNT_W too narrow for image size");
    end

    logic       vsync_d0_q;
    logic       vsync_d1_q;
    logic       href_d0_q;
    logic       href_d1_q;
    logic       clken_d0_q;
    logic       clken_d1_q;
    logic       vsync_rise_s;
    logic       border_s;
    frm_state_e state_q;
    frm_state_e state_d;
    logic [1:0] mode_q;
    logic [1:0] mode_d;
    logic [1:0] mode_eff_s;
    stage1_t    s1_q;
    stage1_t    s1_d;
    logic       bit_q;
    logic       bit_d;

    // Edge is taken against the pixel it arrives with, so that pixel belongs to the new frame.
    assign vsync_rise_s = matrix_frame_vsync & ~vsync_d0_q;

`ifdef VIP_MORPH_BORDER_MASK_EN
    vip_frame_pos_cnt #(
        .IMG_H_DISP (IMG_H_DISP),
        .IMG_V_DISP (IMG_V_DISP),
        .CNT_W      (CNT_W)
    ) u_pos_cnt (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .href_i       (matrix_frame_href),
        .href_prev_i  (href_d0_q),
        .clken_i      (matrix_frame_clken),
        .vsync_rise_i (vsync_rise_s),
        .border_o     (border_s)
    );
`else
    assign border_s = 1'b0;
`endif

    // Sync shift registers: two stages to match the data path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d0_q <= 1'b0;
            vsync_d1_q <= 1'b0;
            href_d0_q  <= 1'b0;
            href_d1_q  <= 1'b0;
            clken_d0_q <= 1'b0;
            clken_d1_q <= 1'b0;
        end else begin
            vsync_d0_q <= matrix_frame_vsync;
            vsync_d1_q <= vsync_d0_q;
            href_d0_q  <= matrix_frame_href;
            href_d1_q  <= href_d0_q;
            clken_d0_q <= matrix_frame_clken;
            clken_d1_q <= clken_d0_q;
        end
    end

    // Frame FSM next state and per-frame mode capture.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        if (vsync_rise_s) begin
            state_d = FRM_ACTIVE;
            mode_d  = mode;
        end else begin
            state_d = state_q;
            mode_d  = mode_q;
        end
        case (state_q)
            FRM_IDLE:   mode_eff_s = MODE_BYPASS;
            FRM_ACTIVE: mode_eff_s = mode_q;
            default:    mode_eff_s = MODE_BYPASS;
        endcase
    end

    // Frame FSM and mode registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FRM_IDLE;
            mode_q  <= MODE_BYPASS;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
        end
    end

    // Stage 1 row reductions; stage 2 combine, border override and hold/clear.
    always_comb begin
        s1_d = s1_q;
        if (!matrix_frame_href) begin
            s1_d = '0;
        end else if (matrix_frame_clken) begin
            s1_d.row_and = {matrix_p11 & matrix_p12 & matrix_p13,
                            matrix_p21 & matrix_p22 & matrix_p23,
                            matrix_p31 & matrix_p32 & matrix_p33};
            s1_d.row_or  = {matrix_p11 | matrix_p12 | matrix_p13,
                            matrix_p21 | matrix_p22 | matrix_p23,
                            matrix_p31 | matrix_p32 | matrix_p33};
            s1_d.centre  = matrix_p22;
            s1_d.border  = border_s;
        end else begin
            s1_d = s1_q;
        end

        bit_d = bit_q;
        if (!href_d0_q) begin
            bit_d = 1'b0;
        end else if (clken_d0_q) begin
            bit_d = s1_q.border ? BORDER_VAL : morph_pixel(mode_eff_s, s1_q);
        end else begin
            bit_d = bit_q;
        end
    end

    // Pipeline stage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q  <= '0;
            bit_q <= 1'b0;
        end else begin
            s1_q  <= s1_d;
            bit_q <= bit_d;
        end
    end

    assign post_frame_vsync = vsync_d1_q;
    assign post_frame_href  = href_d1_q;
    assign post_frame_clken = clken_d1_q;
    assign post_img_bit     = bit_q;

endmodule

// File: tb/tb_vip_bin_morph_3x3.sv
// Directed scoreboard bench for vip_bin_morph_3x3 (IMG 8x6); border expectations follow VIP_MORPH_BORDER_MASK_EN.
module tb_vip_bin_morph_3x3;

    localparam int H = 8;
    localparam int V = 6;
`ifdef VIP_MORPH_BORDER_MASK_EN
    localparam bit MASK_EN = 1'b1;
`else
    localparam bit MASK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] mode;
    logic       vs, hs, ck;
    logic [8:0] win;
    logic       post_vs, post_hs, post_ck, post_bit;

    int total = 0;
    int bad   = 0;
    logic exp_q[$];

    logic       m_prev_vs, m_prev_hs, m_active;
    logic [1:0] m_mode;
    int         m_col, m_row;
    logic       last_exp;
    logic       h_vs, h_hs, h_ck;
    logic       e;

    always #5 clk = ~clk;

    vip_bin_morph_3x3 #(.IMG_H_DISP(H), .IMG_V_DISP(V), .CNT_W(12), .BORDER_VAL(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode),
        .matrix_frame_vsync(vs), .matrix_frame_href(hs), .matrix_frame_clken(ck),
        .matrix_p11(win[8]), .matrix_p12(win[7]), .matrix_p13(win[6]),
        .matrix_p21(win[5]), .matrix_p22(win[4]), .matrix_p23(win[3]),
        .matrix_p31(win[2]), .matrix_p32(win[1]), .matrix_p33(win[0]),
        .post_frame_vsync(post_vs), .post_frame_href(post_hs),
        .post_frame_clken(post_ck), .post_img_bit(post_bit)
    );

    function automatic logic model_px(input logic [1:0] md, input logic [8:0] w, input bit brd);
        logic ero, dil, r;
        ero = &w;
        dil = |w;
        case (md)
            2'b00:   r = w[4];
            2'b01:   r = ero;
            2'b10:   r = dil;
            default: r = dil & ~ero;
        endcase
        if (brd) r = 1'b0;
        return r;
    endfunction

    task automatic model_reset();
        m_prev_vs = 1'b0; m_prev_hs = 1'b0; m_active = 1'b0;
        m_mode = 2'b00; m_col = 0; m_row = 0;
    endtask

    // One pixel-clock of stimulus; the expected output is queued at drive time.
    task automatic cyc(input logic v, input logic h, input logic c, input logic [8:0] w);
        bit rise, brd;
        int pc, pr;
        @(negedge clk);
        vs = v; hs = h; ck = c; win = w;
        rise = v && !m_prev_vs;
        if (rise) begin
            m_active = 1'b1;
            m_mode   = mode;
        end
        pc  = rise ? 0 : m_col;
        pr  = rise ? 0 : m_row;
        brd = MASK_EN && (pc == 0 || pc >= H - 1 || pr == 0 || pr >= V - 1);
        if (h && c) exp_q.push_back(model_px(m_active ? m_mode : 2'b00, w, brd));
        if (!h) m_col = 0;
        else if (c) m_col = pc + 1;
        else m_col = pc;
        if (rise) m_row = 0;
        else if (m_prev_hs && !h) m_row = m_row + 1;
        m_prev_vs = v;
        m_prev_hs = h;
    endtask

    task automatic line(input int n, input logic [8:0] w);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b1, w);
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 9'h000);
    endtask

    task automatic vs_pulse(input logic [1:0] md);
        mode = md;
        cyc(1'b0, 1'b0, 1'b0, 9'h000);
        repeat (2) cyc(1'b1, 1'b0, 1'b0, 9'h000);
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 9'h000);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst_n = 1'b0;
        vs = 1'b0; hs = 1'b0; ck = 1'b0;
        #1;
        total++;
        assert ({post_vs, post_hs, post_ck, post_bit} === 4'b0000)
            else begin bad++; $error("FAIL async_reset observed=%b expected=0000", {post_vs, post_hs, post_ck, post_bit}); end
        exp_q.delete();
        model_reset();
        repeat (n) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Output monitor: sync delay, scoreboard pop, hold and clear checks.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            total++;
            assert ({post_vs, post_hs, post_ck, post_bit} === 4'b0000)
                else begin bad++; $error("FAIL reset_outs observed=%b expected=0000", {post_vs, post_hs, post_ck, post_bit}); end
            h_vs = 1'b0; h_hs = 1'b0; h_ck = 1'b0; last_exp = 1'b0;
        end else begin
            total++;
            assert ({post_vs, post_hs, post_ck} === {h_vs, h_hs, h_ck})
                else begin bad++; $error("FAIL sync_delay observed=%b expected=%b", {post_vs, post_hs, post_ck}, {h_vs, h_hs, h_ck}); end
            if (post_ck && post_hs) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $error("FAIL sb_underflow observed=%b expected=none", post_bit);
                end else begin
                    e = exp_q.pop_front();
                    assert (post_bit === e)
                        else begin bad++; $error("FAIL pixel observed=%b expected=%b t=%0t", post_bit, e, $time); end
                    last_exp = e;
                end
            end else if (post_hs) begin
                total++;
                assert (post_bit === last_exp)
                    else begin bad++; $error("FAIL gap_hold observed=%b expected=%b t=%0t", post_bit, last_exp, $time); end
            end else begin
                total++;
                assert (post_bit === 1'b0)
                    else begin bad++; $error("FAIL href_low_clear observed=%b expected=0", post_bit); end
                last_exp = 1'b0;
            end
            h_vs = vs; h_hs = hs; h_ck = ck;
        end
    end

    initial begin
        rst_n = 1'b0;
        mode = 2'b00; vs = 1'b0; hs = 1'b0; ck = 1'b0; win = 9'h000;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            mode = 2'($urandom); vs = 1'($urandom); hs = 1'($urandom);
            ck = 1'($urandom); win = 9'($urandom);
        end
        @(negedge clk);
        vs = 1'b0; hs = 1'b0; ck = 1'b0; mode = 2'b01;
        @(negedge clk);
        rst_n = 1'b1;

        // After reset, no vsync edge yet: bypass regardless of mode input.
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b1, 9'($urandom));
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 9'h000);

        // Erosion frame, including a clken gap inside href.
        vs_pulse(2'b01);
        line(H, 9'h1FF);
        cyc(1'b0, 1'b1, 1'b1, 9'h1FF);
        cyc(1'b0, 1'b1, 1'b1, 9'h1FF);
        cyc(1'b0, 1'b1, 1'b1, 9'h1FB);
        cyc(1'b0, 1'b1, 1'b1, 9'h1FF);
        repeat (3) cyc(1'b0, 1'b1, 1'b0, 9'h000);
        cyc(1'b0, 1'b1, 1'b1, 9'h1FB);
        repeat (3) cyc(1'b0, 1'b1, 1'b0, 9'h1FF);
        cyc(1'b0, 1'b1, 1'b1, 9'h1FF);
        cyc(1'b0, 1'b1, 1'b1, 9'h1FF);
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 9'h000);

        // Mode changed mid-frame: still erosion until the next vsync edge.
        mode = 2'b10;
        line(H, 9'h040);
        line(H, 9'h040);

        // Dilation frame.
        vs_pulse(2'b10);
        line(H, 9'h040);
        line(H, 9'h040);
        line(H, 9'h040);

        // Edge frame.
        vs_pulse(2'b11);
        line(H, 9'h1FF);
        line(H, 9'h1FF);
        line(H, 9'h010);
        for (int i = 0; i < H; i++) cyc(1'b0, 1'b1, 1'b1, 9'($urandom));
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 9'h000);

        // Border frame: bypass, all-ones, one overlong line and one extra row.
        vs_pulse(2'b00);
        line(H, 9'h1FF);
        line(H, 9'h1FF);
        line(H + 2, 9'h1FF);
        line(H, 9'h1FF);
        line(H, 9'h1FF);
        line(H, 9'h1FF);
        line(H, 9'h1FF);

        // vsync edge coincident with a pixel, mode change on the same cycle.
        mode = 2'b01;
        cyc(1'b0, 1'b1, 1'b1, 9'h1FF);
        cyc(1'b1, 1'b1, 1'b1, 9'h1FF);
        cyc(1'b1, 1'b1, 1'b1, 9'h1FF);
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 9'h000);
        vs_pulse(2'b01);
        line(H, 9'h1FF);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1, 9'h1FF);

        // Reset mid-line, then bypass again until a new vsync edge.
        do_reset(2);
        mode = 2'b10;
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b1, 9'($urandom));
        repeat (4) cyc(1'b0, 1'b0, 1'b0, 9'h000);

        total++;
        assert (exp_q.size() == 0)
            else begin bad++; $error("FAIL sb_drain observed=%0d expected=0", exp_q.size()); end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
